// File: rtl/chimp_pkg.sv
// chimp_pkg: shared constants and types for the chimp-test click mapper.
//   GRID / IDX_W : board size and cell index width
//   NUM_W        : width of the number-to-choose counter
//   DEF_*        : default board geometry and mouse coordinate widths
//   state_t      : click FSM states
package chimp_pkg;

  localparam int GRID          = 8;
  localparam int IDX_W         = 3;
  localparam int NUM_W         = 5;
  localparam int NUM_MAX       = 31;

  localparam int DEF_BOARD_X0  = 160;
  localparam int DEF_BOARD_Y0  = 80;
  localparam int DEF_CELL_SIZE = 40;
  localparam int DEF_X_W       = 10;
  localparam int DEF_Y_W       = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DIV   = 2'd2,
    EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/button_rise_sync.sv
// button_rise_sync: two-flop synchronizer for an asynchronous button level,
// followed by a rising-edge detector.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   btn_async : raw button level
//   rise      : one-cycle pulse on a synchronized 0->1 transition
// PREV_RST sets the reset value of the previous-level register.
module button_rise_sync #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  logic [1:0] prime_q, prime_d;

  // The synchronizer holds 0 for two cycles after reset, which is not the
  // real button level. The previous-level register keeps its reset value
  // until the pipeline has filled, so a button held through reset release
  // never looks like a fresh press.
  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    prime_d = {prime_q[0], 1'b1};
    prev_d  = prime_q[1] ? sync2_q : prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= PREV_RST;
      prime_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

  assign rise = prime_q[1] & sync2_q & ~prev_q;

endmodule

// File: rtl/chimp_click_mapper.sv
// chimp_click_mapper: maps a mouse click in VGA space to a board cell index
// and owns the number-to-choose counter.
//   clk          : system clock
//   iReset       : asynchronous, active-high reset
//   iMouseX/Y    : cursor position in pixels
//   iLeftButton  : raw left-button level (asynchronous)
//   iEnable      : accept clicks (sampled in IDLE only)
//   iNewRound    : number-to-choose back to 1 (wins over iAdvance)
//   iAdvance     : number-to-choose +1, saturating
//   oMouseClick  : one-cycle pulse, oBoxX/oBoxY valid
//   oBoxX/oBoxY  : column/row index of the last click, held until next click
//   oOutside     : one-cycle pulse, enabled click landed off-board
//   oBusy        : FSM not IDLE
//   oNumToChoose : next number the player must click
//
// FSM states
//   state | meaning
//   IDLE  | wait for a button rise with iEnable, capture coordinates
//   CHECK | board range check, convert to board-relative remainders
//   DIV   | repeated subtraction of CELL_SIZE on both axes
//   EMIT  | click pulse, indices presented
module chimp_click_mapper
  import chimp_pkg::*;
#(
  parameter int BOARD_X0  = DEF_BOARD_X0,
  parameter int BOARD_Y0  = DEF_BOARD_Y0,
  parameter int CELL_SIZE = DEF_CELL_SIZE,
  parameter int GRID_N    = GRID,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic [X_W-1:0]   iMouseX,
  input  logic [Y_W-1:0]   iMouseY,
  input  logic             iLeftButton,
  input  logic             iEnable,
  input  logic             iNewRound,
  input  logic             iAdvance,
  output logic             oMouseClick,
  output logic [IDX_W-1:0] oBoxX,
  output logic [IDX_W-1:0] oBoxY,
  output logic             oOutside,
  output logic             oBusy,
  output logic [NUM_W-1:0] oNumToChoose
);

  localparam logic [X_W-1:0]   X_LO   = X_W'(BOARD_X0);
  localparam logic [X_W-1:0]   X_HI   = X_W'(BOARD_X0 + GRID_N * CELL_SIZE);
  localparam logic [X_W-1:0]   CELL_X = X_W'(CELL_SIZE);
  localparam logic [Y_W-1:0]   Y_LO   = Y_W'(BOARD_Y0);
  localparam logic [Y_W-1:0]   Y_HI   = Y_W'(BOARD_Y0 + GRID_N * CELL_SIZE);
  localparam logic [Y_W-1:0]   CELL_Y = Y_W'(CELL_SIZE);
  localparam logic [NUM_W-1:0] NUM_TOP = NUM_W'(NUM_MAX);

  state_t           state_q, state_d;
  // x_q/y_q hold the captured coordinate, then the remainder during DIV.
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [IDX_W-1:0] qx_q, qx_d;
  logic [IDX_W-1:0] qy_q, qy_d;
  logic [IDX_W-1:0] box_x_q, box_x_d;
  logic [IDX_W-1:0] box_y_q, box_y_d;
  logic             outside_q, outside_d;
  logic [NUM_W-1:0] num_q, num_d;

  logic rise;
  logic in_range;
  logic sub_x;
  logic sub_y;

  button_rise_sync #(
    .PREV_RST (1'b1)
  ) u_btn (
    .clk       (clk),
    .rst       (iReset),
    .btn_async (iLeftButton),
    .rise      (rise)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    outside_d = 1'b0;
    in_range  = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
    sub_x     = 1'b0;
    sub_y     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise && iEnable) begin
          x_d     = iMouseX;
          y_d     = iMouseY;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (in_range) begin
          x_d     = x_q - X_LO;
          y_d     = y_q - Y_LO;
          qx_d    = '0;
          qy_d    = '0;
          state_d = DIV;
        end else begin
          outside_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DIV: begin
        sub_x = (x_q >= CELL_X);
        sub_y = (y_q >= CELL_Y);
        if (sub_x) begin
          x_d  = x_q - CELL_X;
          qx_d = qx_q + 1'b1;
        end
        if (sub_y) begin
          y_d  = y_q - CELL_Y;
          qy_d = qy_q + 1'b1;
        end
        // Quotients are final once neither axis can subtract; latch them
        // into the output registers so they are valid during EMIT.
        if (!sub_x && !sub_y) begin
          box_x_d = qx_q;
          box_y_d = qy_q;
          state_d = EMIT;
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    num_d = num_q;
    if (iNewRound) begin
      num_d = NUM_W'(1);
    end else if (iAdvance && (num_q != NUM_TOP)) begin
      num_d = num_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      box_x_q   <= '0;
      box_y_q   <= '0;
      outside_q <= 1'b0;
      num_q     <= NUM_W'(1);
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      outside_q <= outside_d;
      num_q     <= num_d;
    end
  end

  assign oMouseClick  = (state_q == EMIT);
  assign oBusy        = (state_q != IDLE);
  assign oOutside     = outside_q;
  assign oBoxX        = box_x_q;
  assign oBoxY        = box_y_q;
  assign oNumToChoose = num_q;

endmodule

// File: tb/tb_chimp_click_mapper.sv
// tb_chimp_click_mapper: directed, table-driven bench for chimp_click_mapper.
module tb_chimp_click_mapper;

  logic       clk = 1'b0;
  logic       iReset;
  logic [9:0] iMouseX;
  logic [8:0] iMouseY;
  logic       iLeftButton;
  logic       iEnable;
  logic       iNewRound;
  logic       iAdvance;
  logic       oMouseClick;
  logic [2:0] oBoxX;
  logic [2:0] oBoxY;
  logic       oOutside;
  logic       oBusy;
  logic [4:0] oNumToChoose;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chimp_click_mapper dut (
    .clk          (clk),
    .iReset       (iReset),
    .iMouseX      (iMouseX),
    .iMouseY      (iMouseY),
    .iLeftButton  (iLeftButton),
    .iEnable      (iEnable),
    .iNewRound    (iNewRound),
    .iAdvance     (iAdvance),
    .oMouseClick  (oMouseClick),
    .oBoxX        (oBoxX),
    .oBoxY        (oBoxY),
    .oOutside     (oOutside),
    .oBusy        (oBusy),
    .oNumToChoose (oNumToChoose)
  );

  typedef struct {
    int x;
    int y;
    bit en;
    int click_cyc;  // -1: no click expected
    int out_cyc;    // -1: no outside pulse expected
    int bx;
    int by;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a press just after an edge; two edges later the synchronized rise
  // is visible, which is cycle 0. Observe cycles 0..ncyc-1, then release.
  task automatic do_press(input int x, input int y, input bit en, input int ncyc,
                          output int click_cnt, output int click_cyc,
                          output int bx, output int by,
                          output int out_cnt, output int out_cyc,
                          output int busy_cnt);
    click_cnt = 0; click_cyc = -1; bx = -1; by = -1;
    out_cnt = 0; out_cyc = -1; busy_cnt = 0;
    step();
    iMouseX     = 10'(x);
    iMouseY     = 9'(y);
    iEnable     = en;
    iLeftButton = 1'b1;
    step();
    step();
    for (int n = 0; n < ncyc; n++) begin
      if (oMouseClick) begin
        if (click_cnt == 0) begin
          click_cyc = n;
          bx = int'(oBoxX);
          by = int'(oBoxY);
        end
        click_cnt++;
      end
      if (oOutside) begin
        if (out_cnt == 0) out_cyc = n;
        out_cnt++;
      end
      if (oBusy) busy_cnt++;
      step();
    end
    iLeftButton = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int cc, cy, bx, by, oc, oy, bc;
    int exp_busy;

    vecs[0] = '{165, 85,  1'b1,  3, -1, 0, 0};
    vecs[1] = '{479, 280, 1'b1, 10, -1, 7, 5};
    vecs[2] = '{159, 100, 1'b1, -1,  2, 0, 0};
    vecs[3] = '{480, 100, 1'b1, -1,  2, 0, 0};
    vecs[4] = '{200, 400, 1'b1, -1,  2, 0, 0};
    vecs[5] = '{200, 200, 1'b0, -1, -1, 0, 0};
    vecs[6] = '{160, 80,  1'b1,  3, -1, 0, 0};
    vecs[7] = '{399, 399, 1'b1, 10, -1, 5, 7};
    vecs[8] = '{205, 125, 1'b1,  4, -1, 1, 1};

    iReset = 1'b1; iMouseX = '0; iMouseY = '0; iLeftButton = 1'b0;
    iEnable = 1'b0; iNewRound = 1'b0; iAdvance = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_click",   int'(oMouseClick), 0);
    chk("rst_outside", int'(oOutside), 0);
    chk("rst_busy",    int'(oBusy), 0);
    chk("rst_boxx",    int'(oBoxX), 0);
    chk("rst_boxy",    int'(oBoxY), 0);
    chk("rst_num",     int'(oNumToChoose), 1);
    iReset = 1'b0;
    repeat (4) step();

    // Table: one press per record.
    for (int i = 0; i < 9; i++) begin
      do_press(vecs[i].x, vecs[i].y, vecs[i].en, 14, cc, cy, bx, by, oc, oy, bc);
      exp_busy = (vecs[i].click_cyc >= 0) ? vecs[i].click_cyc :
                 (vecs[i].out_cyc >= 0) ? 1 : 0;
      chk($sformatf("v%0d_click_cnt", i), cc, (vecs[i].click_cyc >= 0) ? 1 : 0);
      chk($sformatf("v%0d_click_cyc", i), cy, vecs[i].click_cyc);
      if (vecs[i].click_cyc >= 0) begin
        chk($sformatf("v%0d_boxx", i), bx, vecs[i].bx);
        chk($sformatf("v%0d_boxy", i), by, vecs[i].by);
      end
      chk($sformatf("v%0d_out_cnt", i), oc, (vecs[i].out_cyc >= 0) ? 1 : 0);
      chk($sformatf("v%0d_out_cyc", i), oy, vecs[i].out_cyc);
      chk($sformatf("v%0d_busy_cnt", i), bc, exp_busy);
    end
    chk("num_after_table", int'(oNumToChoose), 1);

    // Button held through reset release gives nothing.
    step();
    iMouseX = 10'd205; iMouseY = 9'd125; iEnable = 1'b1; iLeftButton = 1'b1;
    iReset = 1'b1;
    repeat (3) step();
    iReset = 1'b0;
    cc = 0; bc = 0; oc = 0;
    for (int n = 0; n < 20; n++) begin
      if (oMouseClick) cc++;
      if (oBusy) bc++;
      if (oOutside) oc++;
      step();
    end
    chk("hold_rst_click", cc, 0);
    chk("hold_rst_busy", bc, 0);
    chk("hold_rst_out", oc, 0);
    iLeftButton = 1'b0;
    repeat (5) step();
    do_press(205, 125, 1'b1, 14, cc, cy, bx, by, oc, oy, bc);
    chk("repress_click_cyc", cy, 4);
    chk("repress_boxx", bx, 1);
    chk("repress_boxy", by, 1);

    // Second press while busy is dropped; coordinate change is ignored.
    step();
    iMouseX = 10'd479; iMouseY = 9'd280; iEnable = 1'b1; iLeftButton = 1'b1;
    step();
    step();
    cc = 0; cy = -1; bx = -1; by = -1;
    for (int n = 0; n < 24; n++) begin
      if (oMouseClick) begin
        if (cc == 0) begin
          cy = n; bx = int'(oBoxX); by = int'(oBoxY);
        end
        cc++;
      end
      if (n == 1) begin
        iMouseX = 10'd300; iMouseY = 9'd300;
      end
      if (n == 3) iLeftButton = 1'b0;
      if (n == 5) iLeftButton = 1'b1;
      step();
    end
    iLeftButton = 1'b0;
    repeat (4) step();
    chk("busy_drop_cnt", cc, 1);
    chk("busy_drop_cyc", cy, 10);
    chk("busy_drop_boxx", bx, 7);
    chk("busy_drop_boxy", by, 5);

    // Number counter.
    for (int k = 1; k <= 35; k++) begin
      iAdvance = 1'b1;
      step();
      iAdvance = 1'b0;
      if (k == 29) chk("num_29", int'(oNumToChoose), 30);
      if (k == 30) chk("num_30", int'(oNumToChoose), 31);
    end
    chk("num_sat", int'(oNumToChoose), 31);
    iNewRound = 1'b1; iAdvance = 1'b1;
    step();
    iNewRound = 1'b0; iAdvance = 1'b0;
    chk("num_newround_prio", int'(oNumToChoose), 1);
    iAdvance = 1'b1;
    step();
    step();
    iAdvance = 1'b0;
    chk("num_adv2", int'(oNumToChoose), 3);

    // Reset in the middle of DIV.
    step();
    iMouseX = 10'd479; iMouseY = 9'd280; iLeftButton = 1'b1;
    step();
    step();
    for (int n = 0; n < 4; n++) step();
    chk("middiv_busy_before", int'(oBusy), 1);
    #2;
    iReset = 1'b1;
    #1;
    chk("middiv_busy", int'(oBusy), 0);
    chk("middiv_click", int'(oMouseClick), 0);
    chk("middiv_boxx", int'(oBoxX), 0);
    chk("middiv_num", int'(oNumToChoose), 1);
    iLeftButton = 1'b0;
    repeat (2) step();
    iReset = 1'b0;
    cc = 0;
    for (int n = 0; n < 15; n++) begin
      if (oMouseClick) cc++;
      step();
    end
    chk("middiv_no_pulse", cc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/chimp_click_mapper.md
Name: chimp_click_mapper

Overview:
Upstream neighbour of the chimp-test board datapath. It turns raw VGA-space mouse coordinates and the left-button level into a one-cycle click pulse with a grid cell index (oBoxX/oBoxY). It also owns the "number to choose" counter that the datapath compares against the clicked cell. Cell index is found by iterative subtraction, so no divider is needed.

Parameters:
BOARD_X0, 160, pixel x of board left edge
BOARD_Y0, 80, pixel y of board top edge
CELL_SIZE, 40, cell edge length in pixels
GRID, 8, cells per row/column (index width 3)
X_W, 10, mouse x width
Y_W, 9, mouse y width

Ports:
clk  in  1  system clock
iReset  in  1  asynchronous, active-high reset
iMouseX  in  X_W  cursor x, pixels
iMouseY  in  Y_W  cursor y, pixels
iLeftButton  in  1  raw button level, asynchronous to clk
iEnable  in  1  accept clicks (controller drives from datapath oDoneLoad)
iNewRound  in  1  reset number-to-choose to 1
iAdvance  in  1  increment number-to-choose
oMouseClick  out  1  one-cycle pulse; box indices valid
oBoxX  out  3  column index = (x-BOARD_X0)/CELL_SIZE
oBoxY  out  3  row index = (y-BOARD_Y0)/CELL_SIZE
oOutside  out  1  one-cycle pulse: enabled click landed off-board
oBusy  out  1  high whenever FSM not IDLE
oNumToChoose  out  5  next number the player must click

Behaviour:
- Reset (async, active-high): FSM=IDLE; oMouseClick=0, oOutside=0, oBusy=0, oBoxX=0, oBoxY=0, oNumToChoose=1; both sync flops=0; previous-level register=1.
- Previous-level reset to 1 means a button held through reset release gives no click. The player must release, then press.
- Button path: 2-flop synchronizer, then rise = sync & ~prev.
- FSM IDLE/CHECK/DIV/EMIT; cycle 0 = the IDLE cycle that sees rise with iEnable=1.
  - IDLE: on rise && iEnable, capture iMouseX/iMouseY and go to CHECK. Otherwise stay.
  - CHECK (cycle 1): the click is in range iff BOARD_X0 ≤ x < BOARD_X0+GRID*CELL_SIZE and BOARD_Y0 ≤ y < BOARD_Y0+GRID*CELL_SIZE.
    - Out of range: oOutside=1 in cycle 2, return to IDLE.
    - In range: remX=x-BOARD_X0, remY=y-BOARD_Y0, qx=qy=0, go to DIV.
  - DIV: each cycle, independently for each axis, if rem ≥ CELL_SIZE then subtract CELL_SIZE and increment q. If neither axis subtracted this cycle, go to EMIT. DIV lasts max(qx,qy)+1 cycles.
  - EMIT: oMouseClick=1 for exactly this cycle; oBoxX=qx and oBoxY=qy, registered and held until the next EMIT. Return to IDLE.
- Click latency = 3+max(qx,qy) cycles after cycle 0. Minimum 3, maximum GRID+2 = 10.
- oBusy=1 in CHECK, DIV and EMIT.
- Rises while busy are dropped, not queued.
- iEnable is sampled only in IDLE; a click already in flight completes even if iEnable falls.
- Coordinate changes after capture are ignored.
- Intermediate arithmetic is X_W/Y_W wide and unsigned; the range check precedes subtraction, so no underflow.
- Number counter:
  - iNewRound → 1; iNewRound has priority when asserted together with iAdvance.
  - Otherwise iAdvance → +1, saturating at 31.
  - Independent of the FSM state.
- Reset mid-operation: immediate return to IDLE; no pulse is emitted.

Decomposition:
- Package chimp_pkg:
  - GRID and index width (3)
  - number width (5)
  - state enum typedef (IDLE, CHECK, DIV, EMIT)
  - default board geometry constants
- One sub-module, button_rise_sync: synchronizer plus rise detect, with async reset and a parameterized reset value for the previous-level register.

Test Plan:
1. Reset, then press at (165,85) with iEnable=1 → oMouseClick in cycle 3, box (0,0), oOutside never asserts, oNumToChoose=1.
2. Press at (479,280) → box (7,5), oMouseClick in cycle 10, oBusy high cycles 1–10, then low.
3. Press at (159,100), then at (480,100), then at (200,400) → each gives an oOutside pulse in cycle 2 and no oMouseClick.
4. Press with iEnable=0 → no outputs. Hold the button through iReset release → nothing; release and re-press at (205,125) → box (1,1).
5. Second press during busy at (300,300), issued before the first click's EMIT → exactly one oMouseClick, with the first click's indices.
6. Pulse iAdvance 35 times → oNumToChoose saturates at 31. Assert iNewRound and iAdvance together → 1. Assert iReset mid-DIV → no pulse, oBusy=0 immediately.
